// File: rtl/fp_pkg.sv
// fp_pkg: shared float32 field layout, widths and NaN/Inf classification helpers
package fp_pkg;
  localparam int FP_WIDTH = 32;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int DROP_CNT_W = 16;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;
  function automatic logic is_nan(input fp32_t v);
    return v.exp == '1 && v.mant != '0;
  endfunction
  function automatic logic is_inf(input fp32_t v);
    return v.exp == '1 && v.mant == '0;
  endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational NaN/Inf detection of one float32 value
// Ports: value (fp32_t in), nan / inf (flags out).
// Only built when FP_CLASSIFY_EN is defined, since nothing else instantiates it.
`ifdef FP_CLASSIFY_EN
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t value,
  output logic  nan,
  output logic  inf
);
  assign nan = is_nan(value);
  assign inf = is_inf(value);
endmodule
`endif

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: FWFT circular FIFO capturing multiplier results, counting drops instead of stalling
// Ports: clk, reset (async, active-high); valid_in/data_in from the multiplier;
// out_valid/out_ready/out_data consumer port; count, full, overflow (sticky),
// drop_count (saturating), clear_overflow (sync clear of the drop status).
// Macro FP_CLASSIFY_EN adds sticky nan_seen / inf_seen over accepted pushes.
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FP_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_count,
  input  logic                       clear_overflow
`ifdef FP_CLASSIFY_EN
  ,
  output logic                       nan_seen,
  output logic                       inf_seen
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop, drop;
  // DEPTH need not be a power of two, so wrap by explicit compare
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign out_valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign pop = out_valid && out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;
  assign out_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
      count <= count + CW'(push) - CW'(pop);
      overflow <= drop | (overflow & ~clear_overflow);
      // a drop coinciding with a clear restarts the tally at one
      drop_count <= drop ? (clear_overflow ? DROP_CNT_W'(1) : drop_count + DROP_CNT_W'(drop_count != '1))
                  : clear_overflow ? '0 : drop_count;
    end
`ifdef FP_CLASSIFY_EN
  logic nan, inf;
  fp_classify u_classify (
    .value(fp32_t'(data_in)),
    .nan  (nan),
    .inf  (inf)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      nan_seen <= 1'b0;
      inf_seen <= 1'b0;
    end else begin
      nan_seen <= (push & nan) | (nan_seen & ~clear_overflow);
      inf_seen <= (push & inf) | (inf_seen & ~clear_overflow);
    end
`endif
endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: queue-model checked bench for fp_result_fifo with directed and random traffic
module tb_fp_result_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;
  logic [31:0] data_in = '0, out_data;
  logic out_valid, full, overflow;
  logic [3:0] count;
  logic [15:0] drop_count;
`ifdef FP_CLASSIFY_EN
  logic nan_seen, inf_seen;
`endif
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  logic m_ovf = 1'b0, m_nan = 1'b0, m_inf = 1'b0;
  int m_dc = 0;

  fp_result_fifo #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clear_overflow(clear_overflow)
`ifdef FP_CLASSIFY_EN
    ,
    .nan_seen      (nan_seen),
    .inf_seen      (inf_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [31:0] d);
    valid_in = 1'b1;
    data_in = d;
    tick();
    valid_in = 1'b0;
  endtask

  // Reference model: a bounded queue plus sticky status, updated per clock edge
  always @(posedge clk or posedge reset) begin : model
    bit f, pp, ps, dr;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_dc = 0;
      m_nan = 1'b0;
      m_inf = 1'b0;
    end else begin
      f = q.size() == DEPTH;
      pp = q.size() != 0 && out_ready;
      ps = valid_in && (!f || pp);
      dr = valid_in && f && !pp;
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(data_in);
      if (dr) begin
        m_ovf = 1'b1;
        m_dc = clear_overflow ? 1 : (m_dc < 65535 ? m_dc + 1 : m_dc);
      end else if (clear_overflow) begin
        m_ovf = 1'b0;
        m_dc = 0;
      end
      m_nan = (ps && data_in[30:23] == 8'hff && data_in[22:0] != 0) || (m_nan && !clear_overflow);
      m_inf = (ps && data_in[30:23] == 8'hff && data_in[22:0] == 0) || (m_inf && !clear_overflow);
    end
  end

  always @(negedge clk)
    if (!reset) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_dc));
`ifdef FP_CLASSIFY_EN
      chk("nan_seen", 32'(nan_seen), 32'(m_nan));
      chk("inf_seen", 32'(inf_seen), 32'(m_inf));
`endif
    end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drops", 32'(drop_count), 0);
    // two results, consumer stalled, then released
    push_one(32'hc20c0000);
    push_one(32'hc108a2c0);
    chk("t1_count", 32'(count), 2);
    chk("t1_head", out_data, 32'hc20c0000);
    out_ready = 1'b1;
    tick();
    chk("t1_second", out_data, 32'hc108a2c0);
    tick();
    chk("t1_empty", 32'(out_valid), 0);
    chk("t1_count0", 32'(count), 0);
    out_ready = 1'b0;
    // overfill by two
    for (int i = 1; i <= 10; i++) push_one(32'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_count", 32'(count), 8);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_drops", 32'(drop_count), 2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", out_data, 32'(i));
      tick();
    end
    chk("t2_done", 32'(out_valid), 0);
    out_ready = 1'b0;
    // full FIFO streaming through with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_one(32'(101 + i));
    valid_in = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 32'(109 + k);
      chk("t3_seq", out_data, 32'(101 + k));
      chk("t3_count", 32'(count), 8);
      tick();
    end
    valid_in = 1'b0;
    chk("t3_drops", 32'(drop_count), 2);
    repeat (8) tick();
    out_ready = 1'b0;
    // clear alone, then clear coinciding with a drop
    for (int i = 0; i < 9; i++) push_one(32'(200 + i));
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_drops", 32'(drop_count), 3);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 0);
    chk("t4_clr_drops", 32'(drop_count), 0);
    clear_overflow = 1'b1;
    push_one(32'h55);
    clear_overflow = 1'b0;
    chk("t4_win_ovf", 32'(overflow), 1);
    chk("t4_win_drops", 32'(drop_count), 1);
    // asynchronous reset with 5 entries queued
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("t5_count5", 32'(count), 5);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_count", 32'(count), 0);
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_ovf", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    push_one(32'h3f800000);
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_data", out_data, 32'h3f800000);
    chk("t5_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef FP_CLASSIFY_EN
    push_one(32'h7fc00000);
    chk("t6_nan", 32'(nan_seen), 1);
    chk("t6_noinf", 32'(inf_seen), 0);
    push_one(32'hff800000);
    chk("t6_inf", 32'(inf_seen), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t6_clr_nan", 32'(nan_seen), 0);
    chk("t6_clr_inf", 32'(inf_seen), 0);
    for (int i = 0; i < 6; i++) push_one(32'(i + 1));
    chk("t6_full", 32'(full), 1);
    push_one(32'h7f800000);
    chk("t6_drop_inf", 32'(inf_seen), 0);
    chk("t6_drop_cnt", 32'(drop_count), 1);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
`endif
    // randomized traffic in phases of different producer/consumer bias
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 1000; c++) begin
        valid_in = ($urandom % 4) < (p == 0 ? 1 : 3);
        out_ready = ($urandom % 4) < (p == 2 ? 1 : 3);
        clear_overflow = ($urandom % 40) == 0;
        data_in = ($urandom % 8 == 0) ? {1'($urandom), 8'hff, ($urandom % 2 == 0) ? 23'h0 : 23'($urandom)} : $urandom;
        tick();
      end
    valid_in = 1'b0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_result_fifo.md
Name: fp_result_fifo

Overview:
Downstream buffer for the floating-point multiplier top. It captures every result the multiplier emits on its valid_out/out0 pair into a circular FIFO. The multiplier has no backpressure, so drops are counted and flagged rather than stalled. Results leave through a first-word-fall-through ready/valid port toward the AXI/PS-facing logic.

Parameters:
DEPTH, 8, number of 32-bit entries; legal range 2..256; need not be a power of two.
WIDTH, 32, data width; fixed to fp_pkg::FP_WIDTH, kept as a parameter for reuse.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
valid_in  input  1  multiplier result valid (driven by the multiplier's valid_out)
data_in  input  WIDTH  multiplier result (out0)
out_valid  output  1  head entry present
out_ready  input  1  consumer accepts head entry
out_data  output  WIDTH  head entry, first-word-fall-through
count  output  $clog2(DEPTH+1)  current occupancy
full  output  1  count == DEPTH
overflow  output  1  sticky: at least one result dropped
drop_count  output  16  saturating count of dropped results
clear_overflow  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (asynchronous assert, deasserted on clk edge by upstream synchronizer): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, full=0, overflow=0, drop_count=0. out_data is don't-care while out_valid=0. Memory contents are not reset.
- Reset mid-stream: all queued entries are discarded. No output event occurs in the reset cycle or the first cycle after it.
- push = valid_in && (!full || pop). pop = out_valid && out_ready.
- Push writes data_in to mem[wr_ptr], then wr_ptr advances.
- Pop advances rd_ptr.
- Pointer wrap: when ptr == DEPTH-1, the next value is 0. This is explicit compare logic, not modulo on a power of two.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push+pop:
  - When full: accepted. count stays DEPTH, no drop.
  - When empty: impossible, since pop requires out_valid.
- Latency: a push into an empty FIFO gives out_valid=1 with out_data=data_in on the next cycle (1 cycle). Data order is strict FIFO.
- out_valid = (count != 0). out_data = mem[rd_ptr], driven combinationally from a registered pointer.
- out_data and out_valid remain stable while out_valid && !out_ready.
- Drop: valid_in && full && !pop. The data is discarded, overflow is set the next cycle, and drop_count increments, saturating at 16'hFFFF.
- clear_overflow: next cycle overflow=0 and drop_count=0. If a drop happens in the same cycle, the drop wins: overflow=1 and drop_count=1.
- No FSM beyond the pointer/count datapath. Status outputs (full, count, overflow, drop_count) are registered or derived from registered state, with no combinational path from inputs.

Optional Feature:
FP_CLASSIFY_EN
- Defined: adds sticky outputs nan_seen (1) and inf_seen (1), both set by accepted pushes only.
  - NaN: exp == 8'hFF and mant != 0.
  - Inf: exp == 8'hFF and mant == 0.
  - Both flags are cleared by clear_overflow; a set event in the same cycle as the clear wins.
  - Both reset to 0.
- Undefined: the ports and logic are absent. The rest of the behaviour is identical.

Decomposition:
- fp_pkg:
  - FP_WIDTH=32, EXP_W=8, MANT_W=23.
  - typedef fp32_t (packed struct: sign, exp[7:0], mant[22:0]).
  - Functions is_nan(fp32_t) and is_inf(fp32_t).
  - DROP_CNT_W=16.
- Sub-module fp_classify: combinational is_nan/is_inf from fp32_t. It is instantiated only under FP_CLASSIFY_EN.
- Pointer/count logic stays in the top module.

Test Plan:
1. Reset, then push 32'hc20c0000 then 32'hc108a2c0 with out_ready=0 -> count=2, out_data=c20c0000. Raise out_ready -> c20c0000 then c108a2c0 on consecutive cycles, then out_valid=0, count=0.
2. DEPTH=8, out_ready=0, push 10 values 1..10 -> full=1, count=8, overflow=1, drop_count=2. Drain -> exactly 1..8 in order.
3. Full FIFO, valid_in=1 and out_ready=1 for 20 cycles with incrementing data -> no drops, count stays 8, output sequence is contiguous, pointers wrap at least twice.
4. overflow=1, drop_count=3. Pulse clear_overflow alone -> both 0. Repeat with a drop in the same cycle -> overflow=1, drop_count=1.
5. Assert reset asynchronously mid-cycle with 5 entries queued -> out_valid, count and overflow drop to 0 immediately, before the next clk edge. After release, the first push appears after 1 cycle.
6. FP_CLASSIFY_EN: push 32'h7fc00000 -> nan_seen=1. Push 32'hff800000 -> inf_seen=1. Push 32'h7f800000 while full and dropped -> inf_seen is not set by the dropped push.
